// File: rtl/sortmax_stream.sv
// Streaming sort/max engine: loads a burst of up to DEPTH unsigned words, then
// either selection-sorts it descending (one compare per cycle) or finds its maximum.
module sortmax_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic [CW-1:0]    count
);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, SCAN, SWAP, EMIT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]    pass_i, cand_j, best, emit_e;
  logic [IW-1:0]    load_idx;
  logic             mode_q;

  logic             in_fire, out_fire;
  logic             load_done, scan_end, pass_end, emit_last_next, cand_gt;
  logic [CW-1:0]    count_new;

  assign in_ready  = (state == IDLE) || (state == LOAD);
  assign busy      = (state != IDLE);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // The first accepted beat always lands at index 0 and restarts the count.
  assign count_new = (state == IDLE) ? CW'(1) : count + CW'(1);
  assign load_idx  = (state == IDLE) ? '0 : IW'(count);
  assign load_done = in_fire && (in_last || (count_new == CW'(DEPTH)));

  assign scan_end       = (CW'(cand_j) + CW'(1)) == count;
  assign pass_end       = (CW'(pass_i) + CW'(2)) == count;
  assign emit_last_next = (CW'(emit_e) + CW'(2)) == count;
  // Strict compare keeps the lower index on ties.
  assign cand_gt        = mem[cand_j] > mem[best];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: next-state defaults to the current state first so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, LOAD: begin
        if (load_done)    state_next = (count_new == CW'(1)) ? EMIT : SCAN;
        else if (in_fire) state_next = LOAD;
      end
      SCAN:    if (scan_end) state_next = mode_q ? EMIT : SWAP;
      SWAP:    state_next = pass_end ? EMIT : SCAN;
      EMIT:    if (out_fire && out_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the word array is deliberately left out of reset; every entry read is
  // written by the current burst's load before any compare or emit uses it.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[load_idx] <= in_data;
    end else if (state == SWAP) begin
      mem[pass_i] <= mem[best];
      mem[best]   <= mem[pass_i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      mode_q    <= 1'b0;
      pass_i    <= '0;
      cand_j    <= '0;
      best      <= '0;
      emit_e    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      unique case (state)
        IDLE, LOAD: begin
          pass_i <= '0;
          cand_j <= IW'(1);
          best   <= '0;
          emit_e <= '0;
          if (in_fire) count <= count_new;
          if (in_fire && (state == IDLE)) mode_q <= mode;
        end
        SCAN: begin
          if (cand_gt)   best   <= cand_j;
          if (!scan_end) cand_j <= cand_j + IW'(1);
        end
        SWAP: begin
          pass_i <= pass_i + IW'(1);
          best   <= pass_i + IW'(1);
          cand_j <= pass_i + IW'(2);
        end
        EMIT: begin
          // First EMIT cycle registers beat 0; afterwards each handshake preloads the next.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= mode_q ? mem[best] : mem[emit_e];
            out_last  <= mode_q || (count == CW'(1));
          end else if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              emit_e   <= emit_e + IW'(1);
              out_data <= mem[emit_e + IW'(1)];
              out_last <= emit_last_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
